// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side access bus between the LC-3 MAR/MDR pair and the memory controller.
// The CPU drives the request and the controller returns read data with a ready pulse.
interface lc3_mem_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: one CPU access at a time, routed to an external SRAM with
// programmable wait states or to the keyboard/display memory-mapped registers.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = 16'hFE00
) (
  input  logic          clk,
  input  logic          reset,
  lc3_mem_ctrl_if.slave bus,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [15:0]   sram_addr,
  output logic [15:0]   sram_wdata,
  input  logic [15:0]   sram_rdata,
  input  logic          kb_valid,
  input  logic [7:0]    kb_char,
  output logic          disp_valid,
  output logic [7:0]    disp_char,
  input  logic          disp_ready
);
  localparam logic [15:0] KBSR_ADDR = IO_BASE;
  localparam logic [15:0] KBDR_ADDR = IO_BASE + 16'd2;
  localparam logic [15:0] DSR_ADDR  = IO_BASE + 16'd4;
  localparam logic [15:0] DDR_ADDR  = IO_BASE + 16'd6;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [15:0] rdata_reg;
  logic        ready_reg;
  logic        kbrdy_reg;
  logic        ovr_reg;
  logic [7:0]  kbchar_reg;

  logic        io_req;
  logic        kbdr_read;
  logic        ddr_write;
  logic [15:0] io_rdata;

  assign bus.rdata = rdata_reg;
  assign bus.ready = ready_reg;

  // I/O side effects are decided from the live request on the edge that leaves IDLE.
  always_comb begin
    io_req    = (state_reg == IDLE) && bus.req && (bus.addr >= IO_BASE);
    kbdr_read = io_req && !bus.we && (bus.addr == KBDR_ADDR);
    ddr_write = io_req && bus.we && (bus.addr == DDR_ADDR);
    io_rdata  = 16'h0000;
    if (bus.addr == KBSR_ADDR) begin
      io_rdata = {kbrdy_reg, ovr_reg, 14'b0};
    end else if (bus.addr == KBDR_ADDR) begin
      io_rdata = {8'h00, kbchar_reg};
    end else if (bus.addr == DSR_ADDR) begin
      io_rdata = {~disp_valid, 15'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      rdata_reg    <= 16'h0000;
      ready_reg    <= 1'b0;
      sram_cs      <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= 16'h0000;
      sram_wdata   <= 16'h0000;
      disp_valid   <= 1'b0;
      disp_char    <= 8'h00;
      kbrdy_reg    <= 1'b0;
      ovr_reg      <= 1'b0;
      kbchar_reg   <= 8'h00;
    end else begin
      ready_reg <= 1'b0;

      // A new character beats a simultaneous KBDR read; the read consumed the old one.
      if (kb_valid) begin
        kbchar_reg <= kb_char;
        kbrdy_reg  <= 1'b1;
        ovr_reg    <= kbrdy_reg && !kbdr_read;
      end else if (kbdr_read) begin
        kbrdy_reg <= 1'b0;
        ovr_reg   <= 1'b0;
      end

      // A DDR write only lands when the display slot was empty before this edge.
      if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
      end else if (ddr_write && !disp_valid) begin
        disp_valid <= 1'b1;
        disp_char  <= bus.wdata[7:0];
      end

      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            if (bus.addr < IO_BASE) begin
              state_reg    <= ACCESS;
              sram_cs      <= 1'b1;
              sram_we      <= bus.we;
              sram_addr    <= bus.addr;
              sram_wdata   <= bus.wdata;
              wait_cnt_reg <= WAIT_INIT;
            end else begin
              state_reg <= DONE;
              ready_reg <= 1'b1;
              if (!bus.we) begin
                rdata_reg <= io_rdata;
              end
            end
          end
        end
        ACCESS: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= DONE;
            ready_reg <= 1'b1;
            sram_cs   <= 1'b0;
            sram_we   <= 1'b0;
            if (!sram_we) begin
              rdata_reg <= sram_rdata;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule
